// File: rtl/rn_regfile_p.sv
// ============================================================================
// Module  : rn_regfile_p
// Purpose : Parametrised RNBIP-2 register file (R0 accumulator + RN bank)
//           with command handshake, registered reads, swap, sequenced clear.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rn_regfile_p #(
    parameter int DATA_W = 8,
    parameter int NREG   = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] sel,
    input  logic [DATA_W-1:0] or2_in,
    input  logic [DATA_W-1:0] alu_in,
    output logic [DATA_W-1:0] dataout_a,
    output logic [DATA_W-1:0] dataout_b,
    output logic              rd_valid,
    output logic              cmd_err,
    output logic              wr_zero
);

    localparam logic [2:0] c_op_nop  = 3'b000;
    localparam logic [2:0] c_op_clr  = 3'b001;
    localparam logic [2:0] c_op_rn0  = 3'b010;
    localparam logic [2:0] c_op_r0n  = 3'b011;
    localparam logic [2:0] c_op_or2  = 3'b100;
    localparam logic [2:0] c_op_alu  = 3'b101;
    localparam logic [2:0] c_op_read = 3'b110;
    localparam logic [2:0] c_op_swap = 3'b111;

    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_clear = 1'b1;

    localparam logic [ADDR_W:0]   c_nreg_ext = (ADDR_W + 1)'(NREG);
    localparam logic [ADDR_W-1:0] c_ptr_last = ADDR_W'(NREG - 1);

    logic [DATA_W-1:0] r_regs [NREG];
    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;

    logic              w_accept;
    logic              w_sel_ok;
    logic              w_clearing;
    logic [DATA_W-1:0] w_rn;
    logic              w_wr_rn;
    logic              w_wr_r0;
    logic [DATA_W-1:0] w_rn_data;
    logic [DATA_W-1:0] w_r0_data;
    logic              w_is_write;
    logic [DATA_W-1:0] w_dest_val;
    logic [NREG-1:0]   w_we;
    logic [DATA_W-1:0] w_wd [NREG];

    assign w_accept   = cmd_valid && cmd_ready;
    assign w_sel_ok   = ({1'b0, sel} < c_nreg_ext);
    assign w_clearing = (r_state == c_st_clear);

    // RN read mux; out-of-range selects read as zero and are never committed
    always_comb begin
        w_rn = '0;
        for (int i = 0; i < NREG; i++) begin
            if (sel == ADDR_W'(i)) begin
                w_rn = r_regs[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register / next-state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_accept && (cmd_op == c_op_clr)) begin
                    w_state_nxt = c_st_clear;
                end
            end
            c_st_clear: begin
                if (r_ptr == c_ptr_last) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: w_state_nxt = c_st_idle;
        endcase
    end

    always_comb begin
        cmd_ready = (r_state == c_st_idle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_clearing) begin
            r_ptr <= (r_ptr == c_ptr_last) ? '0 : r_ptr + 1'b1;
        end else begin
            r_ptr <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Command decode
    // ------------------------------------------------------------------
    always_comb begin
        w_wr_rn    = 1'b0;
        w_wr_r0    = 1'b0;
        w_rn_data  = '0;
        w_r0_data  = w_rn;
        w_dest_val = '0;
        if (w_accept && w_sel_ok) begin
            case (cmd_op)
                c_op_rn0: begin
                    w_wr_rn   = 1'b1;
                    w_rn_data = r_regs[0];
                end
                c_op_r0n: begin
                    w_wr_r0   = 1'b1;
                end
                c_op_or2: begin
                    w_wr_rn   = 1'b1;
                    w_rn_data = or2_in;
                end
                c_op_alu: begin
                    w_wr_rn   = 1'b1;
                    w_rn_data = alu_in;
                end
                c_op_swap: begin
                    w_wr_rn   = 1'b1;
                    w_wr_r0   = 1'b1;
                    w_rn_data = r_regs[0];
                end
                default: begin
                    w_wr_rn   = 1'b0;
                end
            endcase
        end
        // For SWAP the flag tracks the new R0, which is the old R[sel]
        w_dest_val = w_wr_r0 ? w_r0_data : w_rn_data;
    end

    assign w_is_write = w_wr_rn || w_wr_r0;

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            w_we[i] = 1'b0;
            w_wd[i] = '0;
            if (w_clearing) begin
                w_we[i] = (r_ptr == ADDR_W'(i));
            end else if (w_wr_rn && (sel == ADDR_W'(i))) begin
                w_we[i] = 1'b1;
                w_wd[i] = w_rn_data;
            end else if (w_wr_r0 && (i == 0)) begin
                w_we[i] = 1'b1;
                w_wd[i] = w_r0_data;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_regs[gi] <= '0;
                end else if (w_we[gi]) begin
                    r_regs[gi] <= w_wd[gi];
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read port, status strobes
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            dataout_a <= '0;
            dataout_b <= '0;
            rd_valid  <= 1'b0;
            cmd_err   <= 1'b0;
            wr_zero   <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            cmd_err  <= 1'b0;
            if (w_accept && w_sel_ok && (cmd_op == c_op_read)) begin
                dataout_a <= r_regs[0];
                dataout_b <= w_rn;
                rd_valid  <= 1'b1;
            end
            if (w_accept && !w_sel_ok &&
                (cmd_op != c_op_nop) && (cmd_op != c_op_clr)) begin
                cmd_err <= 1'b1;
            end
            if (w_is_write) begin
                wr_zero <= (w_dest_val == '0);
            end
        end
    end

endmodule

`default_nettype wire

// File: doc/rn_regfile_p.md
Name: rn_regfile_p

Overview:
- Parametrised register file for the RNBIP-2 datapath, successor to the fixed 8x8 combinational register bank.
- R0 is the accumulator; RN is any register addressed by `sel`.
- Adds a clocked command handshake, registered read ports with a valid strobe, an R0<->RN swap, and a sequenced clear that walks one register per cycle.
- Sits between the operand register (OR2), the ALU result bus and the ALU A/B operand inputs.

Parameters:
- DATA_W, 8: register width in bits.
- NREG, 8: number of registers, >=2; register 0 is R0.
- ADDR_W, 3: width of `sel`; must satisfy 2**ADDR_W >= NREG.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present this cycle.
- cmd_ready  out  1  block can accept a command; low while clearing.
- cmd_op  in  3  000 NOP, 001 CLR, 010 RN<-R0, 011 R0<-RN, 100 RN<-OR2, 101 RN<-ALU, 110 READ, 111 SWAP R0<->RN.
- sel  in  ADDR_W  RN index.
- or2_in  in  DATA_W  operand register data.
- alu_in  in  DATA_W  ALU result.
- dataout_a  out  DATA_W  R0 value captured by READ.
- dataout_b  out  DATA_W  RN value captured by READ.
- rd_valid  out  1  one-cycle pulse, dataout_a/b updated.
- cmd_err  out  1  one-cycle pulse, command rejected (sel >= NREG).
- wr_zero  out  1  last committed write/swap produced an all-zero R[dest].

Behaviour:
- Command acceptance:
  - A command is accepted on a rising edge when cmd_valid && cmd_ready.
  - All effects become visible at that edge; next-cycle state reflects them.
  - Single write port semantics, except SWAP, which writes R0 and RN on the same edge.
- Reset (rst=1 at an edge):
  - All registers become 0.
  - dataout_a = dataout_b = 0; rd_valid = cmd_err = wr_zero = 0; cmd_ready = 1; FSM enters IDLE.
  - Reset overrides everything, including mid-clear.
- FSM states: IDLE, CLEAR.
  - IDLE: cmd_ready=1.
  - Accepted CLR -> CLEAR with clear pointer = 0; `sel` is ignored for CLR.
  - CLEAR: cmd_ready=0. Each cycle writes 0 to R[ptr] and increments ptr.
  - When ptr = NREG-1 is written, return to IDLE. A full clear takes NREG cycles from acceptance.
  - cmd_valid during CLEAR is not accepted; the source must hold the command.
- RN<-R0, RN<-OR2, RN<-ALU: R[sel] <= source.
  - sel=0 with RN<-R0 is a legal no-op write.
- R0<-RN: R0 <= R[sel].
- SWAP:
  - R0 <= old R[sel]; R[sel] <= old R0.
  - sel=0 leaves R0 unchanged.
  - wr_zero reflects the new R0.
- READ:
  - dataout_a <= R0 and dataout_b <= R[sel], both taken from pre-edge state.
  - rd_valid=1 for exactly the following cycle.
  - dataout_a/b hold their value until the next READ or reset.
  - Read latency is 1 cycle; a write accepted in the cycle before the READ is visible to it.
- wr_zero:
  - Updated only by accepted write ops (010, 011, 100, 101, 111): set when the written destination value == 0, else 0.
  - Holds otherwise; cleared by rst; not changed by CLR.
- sel >= NREG (possible when NREG < 2**ADDR_W), for every op except NOP/CLR:
  - No register, output or wr_zero change; cmd_err=1 for one cycle.
- NOP: no effect.
- All arithmetic is pure copy, with no width conversion. The clear pointer is ADDR_W wide and never exceeds NREG-1.

Test Plan:
- Reset, then READ sel=3 -> next cycle rd_valid=1, dataout_a=0x00, dataout_b=0x00, cmd_ready=1.
- RN<-OR2 sel=5 with or2_in=0xA5; R0<-RN sel=5; READ sel=5 -> dataout_a=0xA5, dataout_b=0xA5, wr_zero=0 throughout.
- Load R0=0x12 (via R2<-ALU 0x12 then R0<-RN sel=2), R4<-OR2 0x34, SWAP sel=4, READ sel=4 -> dataout_a=0x34, dataout_b=0x12.
- Fill all 8 regs with 0xFF, CLR with cmd_valid held high on a following READ -> cmd_ready low for exactly 8 cycles, READ accepted on cycle 9, returns 0x00/0x00.
- Assert rst on cycle 3 of a CLEAR -> next cycle IDLE, cmd_ready=1, all regs 0, rd_valid=0.
- NREG=6, ADDR_W=3: RN<-OR2 sel=7 with 0x55 -> cmd_err pulses once, subsequent READ sel=0..5 shows no register changed. Also RN<-ALU sel=1 with alu_in=0x00 -> wr_zero=1.
